// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM window arbiter: client ids, default widths
// and the read-return tag carried down the return pipe.
package vram_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic CLIENT_MAIN   = 1'b0;
  localparam logic CLIENT_PACMAN = 1'b1;

  typedef struct packed {
    logic valid;
    logic client;
  } ret_tag_t;

endpackage

// File: rtl/vram_return_pipe.sv
// Read-return path: shifts the issue tag two stages so it lines up with the
// RAM's registered read data, then registers rdata with a per-client rvalid.
module vram_return_pipe
  import vram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  ret_tag_t          tag_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata
);

  ret_tag_t stage1;
  ret_tag_t stage2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1  <= '0;
      stage2  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      stage1  <= tag_in;
      stage2  <= stage1;
      rvalid0 <= stage2.valid && (stage2.client == CLIENT_MAIN);
      rvalid1 <= stage2.valid && (stage2.client == CLIENT_PACMAN);
      if (stage2.valid) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: rtl/vram_window_arbiter.sv
// Grants a single-port VRAM to the main and pacman clients inside their CE
// windows, capping accepted accesses per window and returning read data.
module vram_window_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_MAX = 144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              main_ce,
  input  logic              pacman_ce,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned      CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(BURST_MAX);

  logic [1:0]       ce;
  logic [1:0]       req;
  logic [1:0]       ack;
  logic [1:0]       ce_q;
  logic [1:0]       rise;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [CNT_W-1:0] cnt [2];

  logic              accept;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  ret_tag_t          tag_in;

  assign ce  = {pacman_ce, main_ce};
  assign req = {req1, req0};
  assign ack = {ack1, ack0};

  // A window opening clears the counter on the same edge, so a rising CE is
  // eligible regardless of what the previous window left in cnt.
  always_comb begin
    rise = '0;
    elig = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      rise[k] = ce[k] && !ce_q[k];
      elig[k] = req[k] && ce[k] && !ack[k] && (rise[k] || (cnt[k] < CNT_CAP));
    end
    grant[0] = elig[0];
    grant[1] = elig[1] && !elig[0];
  end

  always_comb begin
    accept    = |grant;
    sel       = grant[1] ? CLIENT_PACMAN : CLIENT_MAIN;
    sel_we    = grant[1] ? we1    : we0;
    sel_addr  = grant[1] ? addr1  : addr0;
    sel_wdata = grant[1] ? wdata1 : wdata0;
    tag_in    = '{valid: accept && !sel_we, client: sel};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_q <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      ce_q <= ce;
      for (int unsigned k = 0; k < 2; k++) begin
        if (rise[k]) begin
          cnt[k] <= grant[k] ? CNT_W'(1) : '0;
        end else if (grant[k]) begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack0   <= grant[0];
      ack1   <= grant[1];
      mem_en <= accept;
      mem_we <= accept && sel_we;
      if (accept) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

  vram_return_pipe #(
    .DATA_W(DATA_W)
  ) u_return_pipe (
    .clk      (clk),
    .reset    (reset),
    .tag_in   (tag_in),
    .mem_rdata(mem_rdata),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata)
  );

endmodule

// File: tb/tb_vram_window_arbiter.sv
// Bench for vram_window_arbiter: RAM model, cycle model of the arbitration
// rules compared every cycle, plus directed scenarios with literal checks.
module tb_vram_window_arbiter;

  localparam int AW   = 11;
  localparam int DW   = 8;
  localparam int BMAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          main_ce = 1'b0, pacman_ce = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, rvalid0, rvalid1, mem_en, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  vram_window_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .BURST_MAX(BMAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .main_ce  (main_ce),
    .pacman_ce(pacman_ce),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .ack1     (ack1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram    [2**AW];
  logic [DW-1:0] shadow [2**AW];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    int          client;
    logic [7:0]  data;
  } ret_t;

  ret_t          rq[$];
  int            cyc = 0;
  int            used [2] = '{0, 0};
  bit            prev_ce [2] = '{0, 0};
  bit            m_ack [2] = '{0, 0};
  bit            m_rv [2] = '{0, 0};
  bit            m_en = 0, m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  always @(posedge clk) begin
    bit            c_ce [2];
    bit            c_req [2];
    bit            c_we [2];
    logic [AW-1:0] c_addr [2];
    logic [DW-1:0] c_wd [2];
    bit            elig [2];
    int            win;
    if (reset) begin
      rq.delete();
      used = '{0, 0}; prev_ce = '{0, 0}; m_ack = '{0, 0}; m_rv = '{0, 0};
      m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      cyc++;
      c_ce  = '{main_ce, pacman_ce};
      c_req = '{req0, req1};
      c_we  = '{we0, we1};
      c_addr = '{addr0, addr1};
      c_wd  = '{wdata0, wdata1};
      m_rv = '{0, 0};
      if (rq.size() > 0 && rq[0].due == cyc) begin
        m_rv[rq[0].client] = 1;
        m_rdata = rq[0].data;
        void'(rq.pop_front());
      end
      for (int k = 0; k < 2; k++) begin
        if (c_ce[k] && !prev_ce[k]) used[k] = 0;
        prev_ce[k] = c_ce[k];
        elig[k] = c_req[k] && c_ce[k] && !m_ack[k] && (used[k] < BMAX);
      end
      win = elig[0] ? 0 : (elig[1] ? 1 : -1);
      m_ack = '{0, 0}; m_en = 0; m_we = 0;
      if (win >= 0) begin
        m_ack[win] = 1; m_en = 1; m_we = c_we[win];
        m_addr = c_addr[win]; m_wdata = c_wd[win];
        used[win]++;
        if (c_we[win]) shadow[c_addr[win]] = c_wd[win];
        else rq.push_back('{due: cyc + 2, client: win, data: shadow[c_addr[win]]});
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ack0", 32'(ack0), 0);     chk("rst_ack1", 32'(ack1), 0);
      chk("rst_mem_en", 32'(mem_en), 0); chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0); chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_rvalid0", 32'(rvalid0), 0);   chk("rst_rvalid1", 32'(rvalid1), 0);
      chk("rst_rdata", 32'(rdata), 0);
    end else begin
      chk("ack0", 32'(ack0), 32'(m_ack[0]));       chk("ack1", 32'(ack1), 32'(m_ack[1]));
      chk("mem_en", 32'(mem_en), 32'(m_en));       chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr)); chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("rvalid0", 32'(rvalid0), 32'(m_rv[0]));  chk("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
      chk("rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_ack(input int k, input int lim);
    bit got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      got = (k == 0) ? ack0 : ack1;
    end
    chk($sformatf("wait_ack%0d", k), 32'(got), 1);
  endtask

  initial begin
    int n0, nen;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = i[7:0] ^ 8'hC3;
      shadow[i] = i[7:0] ^ 8'hC3;
    end
    ram[11'h123] = 8'h5A;
    shadow[11'h123] = 8'h5A;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // single read
    main_ce = 1; req0 = 1; we0 = 0; addr0 = 11'h123;
    @(negedge clk);
    chk("t1_ack0", 32'(ack0), 1); chk("t1_mem_en", 32'(mem_en), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h123);
    req0 = 0;
    @(negedge clk); @(negedge clk);
    chk("t1_rvalid0", 32'(rvalid0), 1); chk("t1_rdata", 32'(rdata), 32'h5A);
    chk("t1_rvalid1", 32'(rvalid1), 0);
    main_ce = 0;

    // write then read on client 1
    pacman_ce = 1; req1 = 1; we1 = 1; addr1 = 11'h7FF; wdata1 = 8'hA5;
    @(negedge clk);
    chk("t2_ack1", 32'(ack1), 1); chk("t2_mem_we", 32'(mem_we), 1);
    we1 = 0;
    wait_ack(1, 4);
    req1 = 0;
    @(negedge clk); @(negedge clk);
    chk("t2_rvalid1", 32'(rvalid1), 1); chk("t2_rdata", 32'(rdata), 32'hA5);
    pacman_ce = 0;

    // window gating
    req0 = 1; we0 = 0; addr0 = 11'h055; n0 = 0; nen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack0) n0++;
      if (mem_en) nen++;
    end
    chk("t3_no_ack0", 32'(n0), 0); chk("t3_no_mem_en", 32'(nen), 0);
    main_ce = 1;
    @(negedge clk);
    chk("t3_ack0_on_rise", 32'(ack0), 1);
    main_ce = 0;
    @(negedge clk);

    // burst cap with req0 held (reissued after every ack)
    main_ce = 1; n0 = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack0) n0++;
    end
    chk("t4_burst_acks", 32'(n0), BMAX);
    main_ce = 0;
    repeat (2) @(negedge clk);
    main_ce = 1;
    @(negedge clk);
    chk("t4_ack_new_window", 32'(ack0), 1);
    req0 = 0; main_ce = 0;
    repeat (4) @(negedge clk);

    // overlap priority
    main_ce = 1; pacman_ce = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 11'h010; addr1 = 11'h020;
    @(negedge clk);
    chk("t5_ack0_first", 32'(ack0), 1); chk("t5_ack1_waits", 32'(ack1), 0);
    req0 = 0;
    @(negedge clk);
    chk("t5_ack1_next", 32'(ack1), 1);
    req1 = 0;
    @(negedge clk);
    chk("t5_rvalid0", 32'(rvalid0), 1); chk("t5_rdata0", 32'(rdata), 32'hD3);
    @(negedge clk);
    chk("t5_rvalid1", 32'(rvalid1), 1); chk("t5_rdata1", 32'(rdata), 32'hE3);
    main_ce = 0; pacman_ce = 0;
    repeat (2) @(negedge clk);

    // reset in the middle of a read
    main_ce = 1; req0 = 1; addr0 = 11'h123;
    @(negedge clk);
    chk("t6_ack0", 32'(ack0), 1);
    req0 = 0;
    @(posedge clk);
    #1 reset = 1;
    #1;
    chk("t6_rst_ack0", 32'(ack0), 0); chk("t6_rst_mem_en", 32'(mem_en), 0);
    chk("t6_rst_mem_addr", 32'(mem_addr), 0); chk("t6_rst_rdata", 32'(rdata), 0);
    main_ce = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    n0 = 0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) n0++;
    end
    chk("t6_no_stale_rvalid", 32'(n0), 0);
    main_ce = 1; req0 = 1;
    wait_ack(0, 4);
    req0 = 0;
    @(negedge clk); @(negedge clk);
    chk("t6_fresh_rvalid0", 32'(rvalid0), 1); chk("t6_fresh_rdata", 32'(rdata), 32'h5A);
    main_ce = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/vram_window_arbiter.md
# vram_window_arbiter

Grants a single-port synchronous video RAM to two clients (main logic, pacman sprite engine) only inside the time windows signalled by the frame-slot chip enables `main_ce` / `pacman_ce`. Sits directly downstream of the vblank slot selector. It turns its per-frame CE slots into accepted RAM read/write transactions with ack/rvalid handshakes. Caps accesses per window so one client cannot overrun its slot.

## Interface
- `ADDR_W`, 11, RAM address width
- `DATA_W`, 8, RAM data width
- `BURST_MAX`, 144, max accepted accesses per client per CE window (≥1)
- `clk`  in  1  system pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `main_ce`  in  1  window enable, client 0
- `pacman_ce`  in  1  window enable, client 1
- `req0`, `req1`  in  1  access request, held until ack
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `ack0`, `ack1`  out  1  one-cycle pulse: request accepted
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: `rdata` valid for this client's read
- `rdata`  out  DATA_W  read data, shared, qualified by `rvalid*`
- `mem_en`  out  1  RAM access strobe
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after `mem_en` with `mem_we=0`

## Operation
- Client k is eligible on an edge when all of the following hold: `req_k`=1, `ce_k`=1, `ack_k`=0 (the ack cycle is the client's update cycle), and `cnt_k` < BURST_MAX.
- Both clients eligible (CEs overlapping, not expected): client 0 wins, client 1 waits.
- At most one accept per edge. On accept:
  - Register `mem_en`=1 and copy `we`/`addr`/`wdata` onto the `mem_*` outputs.
  - Pulse `ack_k`.
  - Increment `cnt_k`.
- No accept: `mem_en`=0, `mem_we`=0. `mem_addr`/`mem_wdata` hold their last value.
- Reads push a one-entry tag (valid and client id) through a 2-stage return pipe. `mem_rdata` is captured into `rdata` with `rvalid_k`.
- Writes produce no `rvalid`.
- Window counter `cnt_k` (width clog2(BURST_MAX+1)) clears on the rising edge of `ce_k`, detected against a registered copy of `ce_k`.
- At BURST_MAX, `cnt_k` saturates: no further acks in that window. Requests stay pending into the next window.
- `ce_k` falling: no new accepts. In-flight reads still complete and deliver `rvalid`.
- `ce_k` rising in the same cycle as a pending request: the counter clear takes priority, and the request is accepted on that edge with `cnt_k` becoming 1.

## Timing
- Accept at edge E0 produces:
  - `ack_k`=1 and `mem_*` valid during E0→E1.
  - RAM samples at E1; `mem_rdata` valid E1→E2.
  - For reads, `rdata`/`rvalid_k` registered at E2, high E2→E3.
- Read latency is 2 cycles from the ack cycle to the rvalid cycle.
- Per-client throughput: 1 access per 2 cycles.
- Interleaved clients: 1 access per cycle aggregate.
- Reset (asynchronous assert) forces all outputs, counters, CE history registers and the return pipe to 0. The `mem_addr`/`mem_wdata` value is 0.
- Reset mid-operation: in-flight reads are discarded, and no `rvalid` appears after reset release.
- First accept is possible on the first edge after reset deassertion.

## Structure
- Shared package `vram_pkg`:
  - `CLIENT_MAIN`=0, `CLIENT_PACMAN`=1
  - default `ADDR_W`/`DATA_W`
  - return-tag struct {valid, client}
- Sub-module `vram_return_pipe`: 2-stage tag shift and rdata capture, which outputs `rvalid0`/`rvalid1`/`rdata`.
- The top level holds the eligibility logic, priority, window counters and the issue registers.

## Test plan
- Single read: `main_ce`=1, `req0`=1, `we0`=0, `addr0`=0x123, RAM holds 0x5A.
  - Expected: `ack0` at cycle 1, `mem_en`=1 with `mem_addr`=0x123 in the same cycle, `rvalid0`=1 with `rdata`=0x5A at cycle 3.
  - No `rvalid1`.
- Write then read: `pacman_ce`=1.
  - Write 0x7FF←0xA5, expecting `ack1` and `mem_we`=1.
  - Read back 0x7FF, expecting `rvalid1` with `rdata`=0xA5 two cycles after its ack.
- Window gating: `req0` held high with `main_ce`=0 for 20 cycles.
  - Expected: no `ack0`, `mem_en`=0.
  - Raising `main_ce` gives `ack0` on the next edge.
- Burst cap: BURST_MAX=4, `main_ce` high for 20 cycles, `req0` reissued after every ack.
  - Expected: exactly 4 `ack0`.
  - After `main_ce` falls and rises again, the next ack arrives on the first edge.
- Overlap priority: both CEs and both reqs high.
  - Expected: `ack0` first, then `ack1` on the next edge (client 0 is in its ack cycle).
  - Both returns are tagged correctly.
- Reset mid-read: assert `reset` at cycle E1 after a read ack.
  - Expected: all outputs 0 immediately and no `rvalid` after release.
  - A fresh read completes normally.
